// File: rtl/cache_ctrl_pkg.sv
// Shared types and defaults for the cache fill controller.
package cache_ctrl_pkg;

  localparam int ADDR_WIDTH_DEF   = 8;
  localparam int LINE_WIDTH_DEF   = 32;
  localparam int FILL_TIMEOUT_DEF = 16;
  // Counter width able to hold the full timeout value.
  localparam int TIMEOUT_W        = $clog2(FILL_TIMEOUT_DEF + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    CHECK,
    MEM_REQ,
    MEM_WAIT,
    WR_MEM,
    FILL,
    RESP
  } state_t;

endpackage

// File: rtl/cache_fill_ctrl.sv
// Initiator for the cache read/write port: loads look up the cache, misses are
// fetched from memory and filled; stores write through to memory and allocate.
module cache_fill_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int LINE_WIDTH   = LINE_WIDTH_DEF,
  parameter int FILL_TIMEOUT = FILL_TIMEOUT_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  // client
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LINE_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [LINE_WIDTH-1:0] resp_data,
  output logic                  resp_hit,
  output logic                  resp_error,
  // cache
  output logic                  cache_read,
  output logic                  cache_write,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic [LINE_WIDTH-1:0] cache_wdata,
  input  logic                  cache_hit,
  input  logic [LINE_WIDTH-1:0] cache_rdata,
  // memory
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_write,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [LINE_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [LINE_WIDTH-1:0] mem_resp_data
);

  localparam int CNT_W = $clog2(FILL_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILL_TIMEOUT - 1);

  state_t                r_state, w_state_n;
  logic [CNT_W-1:0]      r_cnt, w_cnt_n;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_n;
  logic [LINE_WIDTH-1:0] r_data, w_data_n;
  logic [LINE_WIDTH-1:0] r_resp_data, w_resp_data_n;
  logic                  r_resp_hit, w_resp_hit_n;
  logic                  r_resp_error, w_resp_error_n;
  logic                  r_req_ready;
  logic                  r_resp_valid;
  logic                  r_cache_read;
  logic                  r_cache_write;
  logic                  r_mem_req_valid;
  logic                  r_mem_req_write;

  // Next-state, datapath and response values; every control output is a
  // registered decode of the next state so nothing glitches toward the cache.
  always_comb begin
    w_state_n      = r_state;
    w_cnt_n        = r_cnt;
    w_addr_n       = r_addr;
    w_data_n       = r_data;
    w_resp_data_n  = '0;
    w_resp_hit_n   = 1'b0;
    w_resp_error_n = 1'b0;
    case (r_state)
      IDLE: begin
        // req_ready is high exactly in IDLE, so req_valid alone means accept
        if (req_valid) begin
          w_addr_n  = req_addr;
          w_data_n  = req_wdata;
          w_state_n = req_write ? WR_MEM : LOOKUP;
        end
      end
      LOOKUP: w_state_n = CHECK;
      CHECK: begin
        if (cache_hit) begin
          w_state_n     = RESP;
          w_resp_hit_n  = 1'b1;
          w_resp_data_n = cache_rdata;
        end else begin
          w_state_n = MEM_REQ;
        end
      end
      MEM_REQ: begin
        if (mem_req_ready) begin
          // a response coinciding with the handshake edge is not lost
          if (mem_resp_valid) begin
            w_data_n  = mem_resp_data;
            w_cnt_n   = '0;
            w_state_n = FILL;
          end else begin
            w_state_n = MEM_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        if (mem_resp_valid) begin
          w_data_n  = mem_resp_data;
          w_cnt_n   = '0;
          w_state_n = FILL;
        end
      end
      WR_MEM: begin
        // store data already sits in r_data and is what gets filled
        if (mem_req_ready) begin
          w_cnt_n   = '0;
          w_state_n = FILL;
        end
      end
      FILL: begin
        // cache_hit on the first FILL edge predates our write: ignore it
        if ((r_cnt != '0) && cache_hit) begin
          w_state_n     = RESP;
          w_resp_data_n = r_data;
        end else if (r_cnt == CNT_LAST) begin
          w_state_n      = RESP;
          w_resp_error_n = 1'b1;
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      RESP:    w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_addr          <= '0;
      r_data          <= '0;
      r_resp_data     <= '0;
      r_resp_hit      <= 1'b0;
      r_resp_error    <= 1'b0;
      r_req_ready     <= 1'b1;
      r_resp_valid    <= 1'b0;
      r_cache_read    <= 1'b0;
      r_cache_write   <= 1'b0;
      r_mem_req_valid <= 1'b0;
      r_mem_req_write <= 1'b0;
    end else begin
      r_state         <= w_state_n;
      r_cnt           <= w_cnt_n;
      r_addr          <= w_addr_n;
      r_data          <= w_data_n;
      r_resp_data     <= w_resp_data_n;
      r_resp_hit      <= w_resp_hit_n;
      r_resp_error    <= w_resp_error_n;
      r_req_ready     <= (w_state_n == IDLE);
      r_resp_valid    <= (w_state_n == RESP);
      r_cache_read    <= (w_state_n == LOOKUP);
      r_cache_write   <= (w_state_n == FILL);
      r_mem_req_valid <= (w_state_n == MEM_REQ) || (w_state_n == WR_MEM);
      r_mem_req_write <= (w_state_n == WR_MEM);
    end
  end

  assign req_ready     = r_req_ready;
  assign resp_valid    = r_resp_valid;
  assign resp_data     = r_resp_data;
  assign resp_hit      = r_resp_hit;
  assign resp_error    = r_resp_error;
  assign cache_read    = r_cache_read;
  assign cache_write   = r_cache_write;
  assign cache_addr    = r_addr;
  assign cache_wdata   = r_cache_write ? r_data : '0;
  assign mem_req_valid = r_mem_req_valid;
  assign mem_req_write = r_mem_req_write;
  assign mem_req_addr  = r_mem_req_valid ? r_addr : '0;
  assign mem_req_wdata = r_mem_req_write ? r_data : '0;

endmodule
